spot_centroid_calc: RTL

- Downstream of the CMOS capture stage, on the same 96 MHz domain.
- At each frame start it reads the previous frame's spot statistics through the byte-wide spot-info port: x-sum 24b, y-sum 24b, high-light pixel count 16b.
- It divides each sum by the count with a serial restoring divider and publishes the integer spot centroid with a valid strobe.
- This removes the 24/16 division from the MCU.

---
 rtl/spot_centroid_calc_if.sv | 24 ++
 rtl/spot_centroid_calc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/spot_centroid_calc_if.sv
// Spot-info fetch bus and centroid result signals between the capture stage and the centroid calculator.
interface spot_centroid_calc_if;
  logic        frame_start;
  logic [2:0]  spot_info_addr;
  logic [7:0]  spot_info_data;
  logic        busy;
  logic        spot_valid;
  logic        spot_found;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [15:0] pix_cnt;

  // master: centroid calculator (drives the byte select and results)
  modport master (
    input  frame_start, spot_info_data,
    output spot_info_addr, busy, spot_valid, spot_found, x_pos, y_pos, pix_cnt
  );

  // slave: capture stage / result consumer
  modport slave (
    output frame_start, spot_info_data,
    input  spot_info_addr, busy, spot_valid, spot_found, x_pos, y_pos, pix_cnt
  );
endinterface

// File: rtl/spot_centroid_calc.sv
// Fetches last frame's spot sums/count byte-wise on a frame_start edge and computes the
// saturated integer centroid with one shared serial restoring divider.
module spot_centroid_calc #(
  parameter logic [15:0] MIN_PIX = 16'd4,
  parameter logic [9:0]  POS_MAX = 10'd1023
) (
  input  logic                clk96,
  input  logic                nRst,
  spot_centroid_calc_if.master bus
);

  localparam int unsigned SUM_W  = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned INFO_W = 2 * SUM_W + CNT_W;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, DIV_X, DIV_Y, DONE} state_e;

  state_e              state_q;
  logic                fs_q;
  logic                armed_q;
  logic [3:0]          fcnt_q;
  logic [2:0]          addr_q;
  logic [INFO_W-1:0]   info_q;
  logic [CNT_W-1:0]    rem_q;
  logic [SUM_W-1:0]    dvd_q;
  logic [4:0]          iter_q;
  logic [POS_W-1:0]    x_res_q;
  logic                busy_q;
  logic                valid_q;
  logic                found_q;
  logic [POS_W-1:0]    x_q;
  logic [POS_W-1:0]    y_q;
  logic [CNT_W-1:0]    pix_q;

  logic                start_c;
  logic [SUM_W-1:0]    xsum_c;
  logic [SUM_W-1:0]    ysum_c;
  logic [CNT_W-1:0]    cnt_c;
  logic [CNT_W:0]      shifted_c;
  logic                qbit_c;
  logic [CNT_W-1:0]    rem_next_c;
  logic [SUM_W-1:0]    quo_next_c;
  logic [POS_W-1:0]    sat_c;

  // armed_q masks the first cycle after reset so a level already high is not seen as an edge
  assign start_c = bus.frame_start & ~fs_q & armed_q;

  // One restoring-divide step: dividend shifts out MSB-first, quotient bits shift in at the LSB
  always_comb begin
    xsum_c     = info_q[INFO_W-1 -: SUM_W];
    ysum_c     = info_q[CNT_W +: SUM_W];
    cnt_c      = info_q[CNT_W-1:0];
    shifted_c  = {rem_q, dvd_q[SUM_W-1]};
    qbit_c     = (shifted_c >= {1'b0, cnt_c});
    rem_next_c = qbit_c ? CNT_W'(shifted_c - {1'b0, cnt_c}) : shifted_c[CNT_W-1:0];
    quo_next_c = {dvd_q[SUM_W-2:0], qbit_c};
    sat_c      = (quo_next_c > SUM_W'(POS_MAX)) ? POS_MAX : quo_next_c[POS_W-1:0];
  end

  always_ff @(posedge clk96 or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      fs_q    <= 1'b0;
      armed_q <= 1'b0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      info_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      iter_q  <= '0;
      x_res_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
    end else begin
      fs_q    <= bus.frame_start;
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      if (start_c) begin
        // A new edge always wins: any computation in flight is dropped without a pulse
        state_q <= FETCH;
        addr_q  <= '0;
        fcnt_q  <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            addr_q <= '0;
            busy_q <= 1'b0;
          end
          FETCH: begin
            if (fcnt_q == 4'd8) begin
              state_q <= CHECK;
            end else begin
              info_q <= {info_q[INFO_W-9:0], bus.spot_info_data};
              addr_q <= 3'(addr_q + 3'd1);
              fcnt_q <= 4'(fcnt_q + 4'd1);
            end
          end
          CHECK: begin
            if (cnt_c < MIN_PIX) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              found_q <= 1'b0;
              pix_q   <= cnt_c;
            end else begin
              state_q <= DIV_X;
              rem_q   <= '0;
              dvd_q   <= xsum_c;
              iter_q  <= '0;
            end
          end
          DIV_X: begin
            rem_q  <= rem_next_c;
            dvd_q  <= quo_next_c;
            iter_q <= 5'(iter_q + 5'd1);
            if (iter_q == 5'd23) begin
              x_res_q <= sat_c;
              rem_q   <= '0;
              dvd_q   <= ysum_c;
              iter_q  <= '0;
              state_q <= DIV_Y;
            end
          end
          DIV_Y: begin
            rem_q  <= rem_next_c;
            dvd_q  <= quo_next_c;
            iter_q <= 5'(iter_q + 5'd1);
            if (iter_q == 5'd23) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              found_q <= 1'b1;
              pix_q   <= cnt_c;
              x_q     <= x_res_q;
              y_q     <= sat_c;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.spot_info_addr = addr_q;
  assign bus.busy           = busy_q;
  assign bus.spot_valid     = valid_q;
  assign bus.spot_found     = found_q;
  assign bus.x_pos          = x_q;
  assign bus.y_pos          = y_q;
  assign bus.pix_cnt        = pix_q;

endmodule
